// File: rtl/mmp_datapath_if.sv
// Command/status bundle between the MMP controller and its datapath.
// cmd_err exists only when MMP_DP_CMD_CHECK_EN is defined.
interface mmp_datapath_if #(
  parameter int N = 4
);
  logic           Load_regs;
  logic           Add_regs;
  logic           Shift_regs;
  logic           Decr_P;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           Q0;
  logic           Zero;
  logic [2*N-1:0] product;
`ifdef MMP_DP_CMD_CHECK_EN
  logic           cmd_err;
`endif

  modport master (
    output Load_regs,
    output Add_regs,
    output Shift_regs,
    output Decr_P,
    output multiplicand,
    output multiplier,
    input  Q0,
    input  Zero,
`ifdef MMP_DP_CMD_CHECK_EN
    input  cmd_err,
`endif
    input  product
  );

  modport slave (
    input  Load_regs,
    input  Add_regs,
    input  Shift_regs,
    input  Decr_P,
    input  multiplicand,
    input  multiplier,
    output Q0,
    output Zero,
`ifdef MMP_DP_CMD_CHECK_EN
    output cmd_err,
`endif
    output product
  );
endinterface

// File: rtl/mmp_datapath.sv
// Shift-add multiplier datapath driven by the MMP controller strobes.
// Optional MMP_DP_CMD_CHECK_EN adds a sticky illegal-command flag.
module mmp_datapath #(
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  mmp_datapath_if.slave dp
);
  localparam int PW = $clog2(N + 1);

  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  q_q, q_d;
  logic          c_q, c_d;
  logic [PW-1:0] p_q, p_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    q_d = q_q;
    c_d = c_q;
    p_d = p_q;
    if (dp.Load_regs) begin
      b_d = dp.multiplicand;
      q_d = dp.multiplier;
      a_d = '0;
      c_d = 1'b0;
      p_d = PW'(N);
    end else begin
      if (dp.Add_regs) begin
        {c_d, a_d} = {1'b0, a_q} + {1'b0, b_q};
      end else if (dp.Shift_regs) begin
        {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
      end
      // Saturate at zero so a stray strobe cannot re-arm the count
      if (dp.Decr_P && (p_q != '0)) begin
        p_d = p_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      q_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      q_q <= q_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

  assign dp.Q0      = q_q[0];
  assign dp.Zero    = (p_q == '0);
  assign dp.product = {a_q, q_q};

`ifdef MMP_DP_CMD_CHECK_EN
  logic err_q, err_d;
  logic multi_cmd;

  assign multi_cmd = (dp.Load_regs  && dp.Add_regs)
                  || (dp.Load_regs  && dp.Shift_regs)
                  || (dp.Add_regs   && dp.Shift_regs);

  always_comb begin
    err_d = err_q;
    if (multi_cmd || (dp.Decr_P && (p_q == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dp.cmd_err = err_q;
`endif
endmodule

// File: tb/tb_mmp_datapath.sv
// Scoreboard bench for mmp_datapath (N=4).
// Honours MMP_DP_CMD_CHECK_EN when the build defines it.
module tb_mmp_datapath;
  logic clk;
  logic rst;

  mmp_datapath_if #(.N(4)) dif ();

  mmp_datapath #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] prod;
    logic       q0;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] m_a, m_b, m_q;
  logic       m_c;
  logic [2:0] m_p;
  logic       m_err;

  // Drive one cycle of strobes and queue what the registers should hold after it
  task automatic step(input logic r, input logic l, input logic a,
                      input logic s, input logic d,
                      input logic [3:0] mc, input logic [3:0] mp);
    logic [4:0] sum;
    @(negedge clk);
    rst              = r;
    dif.Load_regs    = l;
    dif.Add_regs     = a;
    dif.Shift_regs   = s;
    dif.Decr_P       = d;
    dif.multiplicand = mc;
    dif.multiplier   = mp;
    if (!r) begin
      m_a = 0; m_b = 0; m_q = 0; m_c = 0; m_p = 0; m_err = 0;
    end else begin
      if ((int'(l) + int'(a) + int'(s)) >= 2) m_err = 1;
      if (d && m_p == 0) m_err = 1;
      if (l) begin
        m_b = mc; m_q = mp; m_a = 0; m_c = 0; m_p = 3'd4;
      end else begin
        if (a) begin
          sum = 5'(m_a) + 5'(m_b);
          m_c = sum[4];
          m_a = sum[3:0];
        end else if (s) begin
          m_q = {m_a[0], m_q[3:1]};
          m_a = {m_c, m_a[3:1]};
          m_c = 0;
        end
        if (d && m_p != 0) m_p = m_p - 3'd1;
      end
    end
    sb.push_back('{{m_a, m_q}, m_q[0], (m_p == 0), m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      step(i >= 2, 0, 0, 0, 0, 4'h0, 4'h0);
      e = sb.pop_front();
      n_cmp++;
      if ({dif.product, dif.Q0, dif.Zero} !== {8'h00, 1'b0, 1'b1}
          || {dif.product, dif.Q0, dif.Zero} !== {e.prod, e.q0, e.zero}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got p=%h q0=%b z=%b want p=00 q0=0 z=1",
                 i, dif.product, dif.Q0, dif.Zero);
      end
`ifdef MMP_DP_CMD_CHECK_EN
      n_cmp++;
      if (dif.cmd_err !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_err[%0d]: got %b want 0", i, dif.cmd_err);
      end
`endif
    end
  endtask

  task automatic test_multiply(input logic [3:0] mc, input logic [3:0] mp,
                               input logic [7:0] want);
    exp_t e;
    bit   first_add = 1;
    step(1, 1, 0, 0, 0, mc, mp);
    e = sb.pop_front();
    n_cmp++;
    if ({dif.product, dif.Zero} !== {e.prod, e.zero}) begin
      n_bad++;
      $display("FAIL load %0dx%0d: got p=%h z=%b want p=%h z=%b",
               mc, mp, dif.product, dif.Zero, e.prod, e.zero);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (dif.Q0 !== mp[k]) begin
        n_bad++;
        $display("FAIL q0 %0dx%0d bit%0d: got %b want %b",
                 mc, mp, k, dif.Q0, mp[k]);
      end
      if (m_q[0]) begin
        step(1, 0, 1, 0, 0, mc, mp);
        e = sb.pop_front();
        n_cmp++;
        if ({dif.product, dif.Zero} !== {e.prod, e.zero}) begin
          n_bad++;
          $display("FAIL add %0dx%0d k%0d: got p=%h z=%b want p=%h z=%b",
                   mc, mp, k, dif.product, dif.Zero, e.prod, e.zero);
        end
        if (first_add && mc == 4'hF && mp == 4'hF) begin
          n_cmp++;
          if ({dut.c_q, dif.product[7:4]} !== 5'h0F) begin
            n_bad++;
            $display("FAIL carry15x15: got c=%b a=%h want c=0 a=f",
                     dut.c_q, dif.product[7:4]);
          end
        end
        first_add = 0;
      end
      step(1, 0, 0, 1, 1, mc, mp);
      e = sb.pop_front();
      n_cmp++;
      if ({dif.product, dif.Q0, dif.Zero} !== {e.prod, e.q0, e.zero}) begin
        n_bad++;
        $display("FAIL shift %0dx%0d k%0d: got p=%h z=%b want p=%h z=%b",
                 mc, mp, k, dif.product, dif.Zero, e.prod, e.zero);
      end
    end
    n_cmp++;
    if ({dif.product, dif.Zero} !== {want, 1'b1}) begin
      n_bad++;
      $display("FAIL product %0dx%0d: got p=%h z=%b want p=%h z=1",
               mc, mp, dif.product, dif.Zero, want);
    end
  endtask

  task automatic test_decr_saturate();
    exp_t e;
    step(1, 1, 0, 0, 0, 4'h2, 4'h6);
    void'(sb.pop_front());
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 0, 1, 4'h0, 4'h0);
      e = sb.pop_front();
      n_cmp++;
      if (dif.Zero !== (i >= 4) || dif.Zero !== e.zero
          || dif.product !== 8'h06) begin
        n_bad++;
        $display("FAIL decr[%0d]: got z=%b p=%h want z=%b p=06",
                 i, dif.Zero, dif.product, (i >= 4));
      end
    end
    n_cmp++;
    if (dut.p_q !== 3'd0) begin
      n_bad++;
      $display("FAIL p_sat: got %0d want 0", dut.p_q);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    step(1, 1, 0, 0, 0, 4'h3, 4'h5);
    step(1, 0, 1, 0, 0, 4'h3, 4'h5);
    step(1, 0, 0, 1, 1, 4'h3, 4'h5);
    step(0, 0, 1, 0, 1, 4'h3, 4'h5);
    for (int i = 0; i < 3; i++) void'(sb.pop_front());
    e = sb.pop_front();
    n_cmp++;
    if ({dif.product, dif.Q0, dif.Zero} !== {8'h00, 1'b0, 1'b1}
        || dif.product !== e.prod) begin
      n_bad++;
      $display("FAIL mid_reset: got p=%h q0=%b z=%b want p=00 q0=0 z=1",
               dif.product, dif.Q0, dif.Zero);
    end
  endtask

  task automatic test_cmd_conflict();
    exp_t e;
    step(1, 1, 1, 0, 0, 4'h6, 4'h3);
    step(1, 0, 0, 0, 0, 4'h6, 4'h3);
    step(1, 0, 0, 0, 0, 4'h6, 4'h3);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if ({dif.product, dif.Zero} !== {8'h03, 1'b0}
          || dif.product !== e.prod) begin
        n_bad++;
        $display("FAIL conflict_load[%0d]: got p=%h z=%b want p=03 z=0",
                 i, dif.product, dif.Zero);
      end
`ifdef MMP_DP_CMD_CHECK_EN
      n_cmp++;
      if (dif.cmd_err !== 1'b1 || e.err !== 1'b1) begin
        n_bad++;
        $display("FAIL cmd_err[%0d]: got %b want 1", i, dif.cmd_err);
      end
`endif
    end
    step(0, 0, 0, 0, 0, 4'h0, 4'h0);
    e = sb.pop_front();
    n_cmp++;
    if (dif.product !== 8'h00 || dif.Zero !== 1'b1) begin
      n_bad++;
      $display("FAIL conflict_reset: got p=%h z=%b want p=00 z=1",
               dif.product, dif.Zero);
    end
`ifdef MMP_DP_CMD_CHECK_EN
    n_cmp++;
    if (dif.cmd_err !== 1'b0 || e.err !== 1'b0) begin
      n_bad++;
      $display("FAIL cmd_err_clear: got %b want 0", dif.cmd_err);
    end
`endif
  endtask

  initial begin
    rst              = 1'b0;
    dif.Load_regs    = 1'b0;
    dif.Add_regs     = 1'b0;
    dif.Shift_regs   = 1'b0;
    dif.Decr_P       = 1'b0;
    dif.multiplicand = 4'h0;
    dif.multiplier   = 4'h0;
    m_a = 0; m_b = 0; m_q = 0; m_c = 0; m_p = 0; m_err = 0;
    test_reset();
    test_multiply(4'h3, 4'h5, 8'h0F);
    test_multiply(4'hF, 4'hF, 8'hE1);
    test_multiply(4'h0, 4'h9, 8'h00);
    test_multiply(4'h7, 4'h0, 8'h00);
    test_multiply(4'hB, 4'hD, 8'h8F);
    test_decr_saturate();
    test_reset_mid();
    test_cmd_conflict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
